// File: rtl/frame_sequencer_if.sv
// Bus bundle for frame_sequencer: upstream sample handshake, downstream word handshake,
// word-select strobes and status.
interface frame_sequencer_if;
    logic        enable;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        signal_f1;
    logic        signal_f2;
    logic        signal_d;
    logic [15:0] sf_count;
    logic        fill_flag;
    logic        busy;

    modport master (
        output enable, data_in, data_valid, out_ready,
        input  data_ready, out_word, out_valid, signal_f1, signal_f2, signal_d,
               sf_count, fill_flag, busy
    );

    modport slave (
        input  enable, data_in, data_valid, out_ready,
        output data_ready, out_word, out_valid, signal_f1, signal_f2, signal_d,
               sf_count, fill_flag, busy
    );
endinterface

// File: rtl/frame_sequencer.sv
// Telemetry frame builder: SYNC1, SYNC2, frame counter, then WORDS_PER_FRAME data words,
// padding with FILL_WORD when upstream stalls so the frame cadence is preserved.
module frame_sequencer #(
    parameter int unsigned WORDS_PER_FRAME = 8,
    parameter logic [15:0] SYNC1           = 16'hEB90,
    parameter logic [15:0] SYNC2           = 16'h146F,
    parameter int unsigned FILL_TIMEOUT    = 64,
    parameter logic [15:0] FILL_WORD       = 16'h0000
) (
    input logic               clk,
    input logic               reset,
    frame_sequencer_if.slave  bus
);

    localparam int unsigned WCW = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int unsigned TOW = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
    localparam logic [WCW-1:0] LastWord = WCW'(WORDS_PER_FRAME - 1);
    localparam logic [TOW-1:0] LastIdle = TOW'(FILL_TIMEOUT - 1);

    // StEof: last data word of the frame is in the output register.
    typedef enum logic [2:0] {StIdle, StF1, StF2, StCnt, StData, StEof} state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [TOW-1:0] idle_cnt_q, idle_cnt_d;
    logic [15:0]    sf_count_q, sf_count_d;
    logic [15:0]    out_word_q, out_word_d;
    logic           out_valid_q, out_valid_d;
    logic           f1_q, f1_d;
    logic           f2_q, f2_d;
    logic           d_q, d_d;
    logic           fill_q, fill_d;

    logic load;
    logic in_data;
    logic take;
    logic fill;
    logic last;

    assign load    = ~out_valid_q | bus.out_ready;
    assign in_data = (state_q == StCnt) | (state_q == StData);
    assign take    = in_data & load & bus.data_valid;
    // Pad on the FILL_TIMEOUT-th consecutive stalled load cycle.
    assign fill    = in_data & load & ~bus.data_valid & (idle_cnt_q == LastIdle);
    assign last    = (take | fill) & (word_cnt_q == LastWord);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StEof: if (load) state_d = bus.enable ? StF1 : StIdle;
            StF1:          if (load) state_d = StF2;
            StF2:          if (load) state_d = StCnt;
            StCnt, StData: if (take | fill) state_d = last ? StEof : StData;
            default:       state_d = StIdle;
        endcase
    end

    always_comb begin
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        f1_d        = f1_q;
        f2_d        = f2_q;
        d_d         = d_q;
        fill_d      = fill_q;
        word_cnt_d  = word_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        sf_count_d  = sf_count_q;
        if (load) begin
            // Register drains to all-zero unless a new word is loaded below.
            out_valid_d = 1'b0;
            out_word_d  = '0;
            f1_d        = 1'b0;
            f2_d        = 1'b0;
            d_d         = 1'b0;
            fill_d      = 1'b0;
            unique case (state_q)
                StIdle, StEof: begin
                    if (bus.enable) begin
                        out_valid_d = 1'b1;
                        out_word_d  = SYNC1;
                        f1_d        = 1'b1;
                        idle_cnt_d  = '0;
                    end
                end
                StF1: begin
                    out_valid_d = 1'b1;
                    out_word_d  = SYNC2;
                    f2_d        = 1'b1;
                end
                StF2: begin
                    out_valid_d = 1'b1;
                    out_word_d  = sf_count_q;
                end
                StCnt, StData: begin
                    if (take || fill) begin
                        out_valid_d = 1'b1;
                        out_word_d  = take ? bus.data_in : FILL_WORD;
                        d_d         = 1'b1;
                        fill_d      = fill;
                        idle_cnt_d  = '0;
                        word_cnt_d  = word_cnt_q + WCW'(1);
                        if (last) begin
                            word_cnt_d = '0;
                            sf_count_d = sf_count_q + 16'd1;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + TOW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            f1_q        <= 1'b0;
            f2_q        <= 1'b0;
            d_q         <= 1'b0;
            fill_q      <= 1'b0;
            word_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            sf_count_q  <= '0;
        end else begin
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            f1_q        <= f1_d;
            f2_q        <= f2_d;
            d_q         <= d_d;
            fill_q      <= fill_d;
            word_cnt_q  <= word_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            sf_count_q  <= sf_count_d;
        end
    end

    // A reset cycle discards whatever sits on data_in, so never signal acceptance then.
    assign bus.data_ready = in_data & load & ~fill & ~reset;
    assign bus.out_word   = out_word_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.signal_f1  = f1_q;
    assign bus.signal_f2  = f2_q;
    assign bus.signal_d   = d_q;
    assign bus.fill_flag  = fill_q;
    assign bus.sf_count   = sf_count_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: vector table for framing/reset/enable-drop,
// hand sequences for backpressure, fill padding and frame-counter wrap.
module tb_frame_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] sample = 16'd1;
    logic acc = 1'b0;
    int ncyc = 0;
    int viol = 0;
    int n_run = 0;
    int n_fail = 0;

    frame_sequencer_if bus();

    frame_sequencer #(
        .WORDS_PER_FRAME(4),
        .SYNC1(16'hEB90),
        .SYNC2(16'h146F),
        .FILL_TIMEOUT(64),
        .FILL_WORD(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  flg;
        int          cyc;
    } ent_t;
    ent_t log_q[$];

    // Upstream source: increments on each accepted sample.
    assign bus.data_in = sample;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        acc  <= bus.data_valid && bus.data_ready && !reset;
        if (!reset && bus.out_valid && bus.out_ready)
            log_q.push_back('{word: bus.out_word,
                              flg: {bus.signal_f1, bus.signal_f2, bus.signal_d, bus.fill_flag},
                              cyc: ncyc});
        if (bus.out_valid && !bus.out_ready && bus.data_ready) viol <= viol + 1;
    end

    always @(posedge clk) begin
        if (reset) sample <= 16'd1;
        else if (acc) sample <= sample + 16'd1;
    end

    typedef struct {
        logic rst, en, dv, ordy;
        logic [6:0]  flg;  // {out_valid, f1, f2, d, fill, busy, data_ready}
        logic [15:0] word;
        logic [15:0] sf;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic en, input logic dv,
                                input logic ordy, input logic [6:0] flg,
                                input logic [15:0] word, input logic [15:0] sf);
        vec_t v;
        v.rst = rst; v.en = en; v.dv = dv; v.ordy = ordy;
        v.flg = flg; v.word = word; v.sf = sf;
        return v;
    endfunction

    function automatic logic [38:0] obs();
        return {bus.out_valid, bus.signal_f1, bus.signal_f2, bus.signal_d, bus.fill_flag,
                bus.busy, bus.data_ready, bus.out_word, bus.sf_count};
    endfunction

    function automatic logic [36:0] snap();
        return {bus.out_valid, bus.signal_f1, bus.signal_f2, bus.signal_d, bus.fill_flag,
                bus.out_word, bus.sf_count};
    endfunction

    function automatic logic [15:0] lw(input int i);
        if (i < log_q.size()) return log_q[i].word;
        return 16'hxxxx;
    endfunction

    function automatic logic [3:0] lf(input int i);
        if (i < log_q.size()) return log_q[i].flg;
        return 4'hx;
    endfunction

    function automatic int lc(input int i);
        if (i < log_q.size()) return log_q[i].cyc;
        return -1000;
    endfunction

    // Expected handshaked word i of continuous framing from reset, 4 data words/frame.
    function automatic logic [15:0] exp_word(input int i);
        int f;
        int p;
        f = i / 7;
        p = i % 7;
        if (p == 0) return 16'hEB90;
        if (p == 1) return 16'h146F;
        if (p == 2) return 16'(f);
        return 16'(4 * f + p - 2);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic dv, input logic ordy);
        reset          = rst;
        bus.enable     = en;
        bus.data_valid = dv;
        bus.out_ready  = ordy;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[23];

    initial begin
        int base;
        int v0;
        logic [36:0] s;
        logic ordy;
        logic [15:0] exp_w[11];
        logic [3:0]  exp_f[11];

        // Framing, reset mid-DATA, and enable dropped after the second data word.
        vecs[0]  = mk(1, 0, 0, 1, 7'b0000000, 16'h0000, 16'd0);
        vecs[1]  = mk(0, 1, 1, 1, 7'b1100010, 16'hEB90, 16'd0);
        vecs[2]  = mk(0, 1, 1, 1, 7'b1010010, 16'h146F, 16'd0);
        vecs[3]  = mk(0, 1, 1, 1, 7'b1000011, 16'h0000, 16'd0);
        vecs[4]  = mk(0, 1, 1, 1, 7'b1001011, 16'h0001, 16'd0);
        vecs[5]  = mk(0, 1, 1, 1, 7'b1001011, 16'h0002, 16'd0);
        vecs[6]  = mk(0, 1, 1, 1, 7'b1001011, 16'h0003, 16'd0);
        vecs[7]  = mk(0, 1, 1, 1, 7'b1001010, 16'h0004, 16'd1);
        vecs[8]  = mk(0, 1, 1, 1, 7'b1100010, 16'hEB90, 16'd1);
        vecs[9]  = mk(0, 1, 1, 1, 7'b1010010, 16'h146F, 16'd1);
        vecs[10] = mk(0, 1, 1, 1, 7'b1000011, 16'h0001, 16'd1);
        vecs[11] = mk(0, 1, 1, 1, 7'b1001011, 16'h0005, 16'd1);
        vecs[12] = mk(0, 1, 1, 1, 7'b1001011, 16'h0006, 16'd1);
        vecs[13] = mk(1, 1, 1, 1, 7'b0000000, 16'h0000, 16'd0);
        vecs[14] = mk(0, 1, 1, 1, 7'b1100010, 16'hEB90, 16'd0);
        vecs[15] = mk(0, 1, 1, 1, 7'b1010010, 16'h146F, 16'd0);
        vecs[16] = mk(0, 1, 1, 1, 7'b1000011, 16'h0000, 16'd0);
        vecs[17] = mk(0, 1, 1, 1, 7'b1001011, 16'h0001, 16'd0);
        vecs[18] = mk(0, 1, 1, 1, 7'b1001011, 16'h0002, 16'd0);
        vecs[19] = mk(0, 0, 1, 1, 7'b1001011, 16'h0003, 16'd0);
        vecs[20] = mk(0, 0, 1, 1, 7'b1001010, 16'h0004, 16'd1);
        vecs[21] = mk(0, 0, 1, 1, 7'b0000000, 16'h0000, 16'd1);
        vecs[22] = mk(0, 0, 1, 1, 7'b0000000, 16'h0000, 16'd1);

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].dv, vecs[i].ordy);
            check($sformatf("vec%0d", i), 64'(obs()),
                  64'({vecs[i].flg, vecs[i].word, vecs[i].sf}));
        end

        // Backpressure: out_ready toggling, words held, none lost or duplicated.
        step(1, 0, 0, 1);
        base = log_q.size();
        v0 = viol;
        for (int k = 0; k < 40; k++) begin
            s = snap();
            ordy = ((k % 2) != 0);
            step(0, 1, 1, ordy);
            if (s[36] && !ordy) check($sformatf("hold%0d", k), 64'(snap()), 64'(s));
        end
        check("bp_count", 64'(log_q.size() - base >= 14), 64'(1));
        for (int i = 0; i < 14; i++)
            check($sformatf("bp_word%0d", i), 64'(lw(base + i)), 64'(exp_word(i)));
        check("bp_ready_viol", 64'(viol - v0), 64'(0));

        // Fill padding during a 200-cycle upstream stall.
        exp_w = '{16'hEB90, 16'h146F, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
                  16'hEB90, 16'h146F, 16'h0001, 16'h0002};
        exp_f = '{4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0011, 4'b0011, 4'b0011,
                  4'b1000, 4'b0100, 4'b0000, 4'b0010};
        step(1, 0, 0, 1);
        base = log_q.size();
        for (int k = 0; k < 4; k++) step(0, 1, 1, 1);
        for (int k = 0; k < 200; k++) step(0, 1, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 1, 1, 1);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("fill_word%0d", i), 64'(lw(base + i)), 64'(exp_w[i]));
            check($sformatf("fill_flags%0d", i), 64'(lf(base + i)), 64'(exp_f[i]));
        end
        for (int i = 3; i < 6; i++)
            check($sformatf("fill_gap%0d", i), 64'(lc(base + i + 1) - lc(base + i)), 64'(64));

        // Frame counter wrap from FFFF to 0000.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        force dut.sf_count_q = 16'hFFFF;
        step(0, 0, 0, 1);
        release dut.sf_count_q;
        step(0, 0, 0, 1);
        check("wrap_preload", 64'(bus.sf_count), 64'(16'hFFFF));
        base = log_q.size();
        for (int k = 0; k < 16; k++) step(0, 1, 1, 1);
        check("wrap_cnt_ffff", 64'(lw(base + 2)), 64'(16'hFFFF));
        check("wrap_cnt_0000", 64'(lw(base + 9)), 64'(16'h0000));
        check("wrap_sf_after", 64'(bus.sf_count), 64'(16'h0001));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
